rv_i2c_target: RTL



---
 rtl/rv_i2c_target_pkg.sv | 11 +
 rtl/rv_i2c_line_filter.sv | 35 +++
 rtl/rv_i2c_target.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rv_i2c_target_pkg.sv
// rv_i2c_target_pkg: shared state encoding, bus event type and pad constants for the I2C target
package rv_i2c_target_pkg;
  localparam logic I2C_RELEASED = 1'b1;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_e;
  typedef struct packed {
    logic start;
    logic stop;
  } bus_ev_t;
endpackage

// File: rtl/rv_i2c_line_filter.sv
// rv_i2c_line_filter: 2-flop synchronizer, run-length glitch filter and edge detect for one bus line
module rv_i2c_line_filter #(
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [1:0] sync_q;
  logic [3:0] cnt_q;
  logic lvl_q, rise_q, fall_q, accept;
  assign accept = (sync_q[1] != lvl_q) && (cnt_q == 4'(FILTER_DEPTH - 1));
  // filtered level follows the synchronized line only after FILTER_DEPTH consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      lvl_q  <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= (sync_q[1] == lvl_q || accept) ? '0 : cnt_q + 4'd1;
      lvl_q  <= accept ? sync_q[1] : lvl_q;
      rise_q <= accept & sync_q[1];
      fall_q <= accept & ~sync_q[1];
    end
  end
  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

// File: rtl/rv_i2c_target.sv
// rv_i2c_target: 7-bit I2C target with RX/TX byte streams; clock stretching enabled by RV_I2C_TARGET_CLOCK_STRETCH_EN
module rv_i2c_target
  import rv_i2c_target_pkg::*;
#(
  parameter logic [6:0]  ADDRESS      = 7'h50,
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_first,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       err_pulse
);
  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q, rx_data_q;
  logic rw_q, sda_t_q, rx_valid_q, rx_first_q, first_pend_q, captured_q;
  logic tx_ready_q, busy_q, start_q, stop_q, err_q;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic addr_hit, tx_load;
  bus_ev_t ev;
`ifdef RV_I2C_TARGET_CLOCK_STRETCH_EN
  logic scl_t_q, rx_wait_q, tx_wait_q;
  assign scl_t = scl_t_q;
`else
  assign scl_t = I2C_RELEASED;
`endif
  rv_i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl (
    .clk(clk), .rst(rst), .line_i(scl_i), .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );
  rv_i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda (
    .clk(clk), .rst(rst), .line_i(sda_i), .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );
  assign ev.start = sda_fall & scl_lvl;
  assign ev.stop  = sda_rise & scl_lvl;
  assign addr_hit = (shift_q[7:1] == ADDRESS) && (|shift_q[7:1]);
  assign tx_load  = scl_fall && ((state_q == ADDR_ACK && rw_q) || (state_q == RD_ACK && !shift_q[0]));
  // protocol FSM: bus events win over SCL edges; SDA drive changes are registered after a filtered SCL fall
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rw_q         <= 1'b0;
      sda_t_q      <= I2C_RELEASED;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_first_q   <= 1'b0;
      first_pend_q <= 1'b0;
      captured_q   <= 1'b0;
      tx_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef RV_I2C_TARGET_CLOCK_STRETCH_EN
      scl_t_q      <= I2C_RELEASED;
      rx_wait_q    <= 1'b0;
      tx_wait_q    <= 1'b0;
`endif
    end else begin
      tx_ready_q <= 1'b0;
      start_q    <= ev.start;
      stop_q     <= ev.stop & ~ev.start;
      err_q      <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (ev.start || ev.stop) begin
        state_q   <= ev.start ? ADDR : IDLE;
        bit_cnt_q <= '0;
        sda_t_q   <= I2C_RELEASED;
        busy_q    <= ev.start ? busy_q : 1'b0;
`ifdef RV_I2C_TARGET_CLOCK_STRETCH_EN
        scl_t_q   <= I2C_RELEASED;
        rx_wait_q <= 1'b0;
        tx_wait_q <= 1'b0;
`endif
      end else begin
        if (scl_rise && (state_q == ADDR || state_q == WR_DATA || state_q == RD_ACK))
          shift_q <= {shift_q[6:0], sda_lvl};
        if (scl_rise && (state_q == ADDR || state_q == WR_DATA))
          bit_cnt_q <= bit_cnt_q + 4'd1;
        if (scl_rise && state_q == WR_DATA && bit_cnt_q == 4'd7) begin
          captured_q <= !rx_valid_q;
          if (!rx_valid_q) begin
            rx_valid_q   <= 1'b1;
            rx_data_q    <= {shift_q[6:0], sda_lvl};
            rx_first_q   <= first_pend_q;
            first_pend_q <= 1'b0;
          end
        end
        if (scl_fall) begin
          case (state_q)
            ADDR: if (bit_cnt_q == 4'd8) begin
              state_q      <= addr_hit ? ADDR_ACK : IGNORE;
              sda_t_q      <= addr_hit ? 1'b0 : I2C_RELEASED;
              busy_q       <= busy_q | addr_hit;
              first_pend_q <= addr_hit;
              rw_q         <= shift_q[0];
              bit_cnt_q    <= '0;
            end
            ADDR_ACK: begin
              state_q   <= rw_q ? RD_DATA : WR_DATA;
              sda_t_q   <= I2C_RELEASED;
              bit_cnt_q <= '0;
            end
            WR_DATA: if (bit_cnt_q == 4'd8) begin
              state_q   <= WR_ACK;
              bit_cnt_q <= '0;
`ifdef RV_I2C_TARGET_CLOCK_STRETCH_EN
              sda_t_q   <= captured_q ? 1'b0 : I2C_RELEASED;
              scl_t_q   <= captured_q ? I2C_RELEASED : 1'b0;
              rx_wait_q <= !captured_q;
`else
              sda_t_q   <= captured_q ? 1'b0 : I2C_RELEASED;
              err_q     <= !captured_q;
`endif
            end
            WR_ACK: begin
              state_q   <= WR_DATA;
              sda_t_q   <= I2C_RELEASED;
              bit_cnt_q <= '0;
            end
            RD_DATA: begin
              state_q   <= (bit_cnt_q == 4'd7) ? RD_ACK : RD_DATA;
              sda_t_q   <= (bit_cnt_q == 4'd7) ? I2C_RELEASED : shift_q[6];
              shift_q   <= {shift_q[6:0], 1'b0};
              bit_cnt_q <= (bit_cnt_q == 4'd7) ? '0 : bit_cnt_q + 4'd1;
            end
            RD_ACK: begin
              state_q   <= shift_q[0] ? IGNORE : RD_DATA;
              bit_cnt_q <= '0;
            end
            default: ;
          endcase
        end
        if (tx_load) begin
          if (tx_valid) begin
            shift_q    <= tx_data;
            sda_t_q    <= tx_data[7];
            tx_ready_q <= 1'b1;
          end else begin
`ifdef RV_I2C_TARGET_CLOCK_STRETCH_EN
            sda_t_q   <= I2C_RELEASED;
            scl_t_q   <= 1'b0;
            tx_wait_q <= 1'b1;
`else
            shift_q   <= 8'hFF;
            sda_t_q   <= I2C_RELEASED;
            err_q     <= 1'b1;
`endif
          end
        end
`ifdef RV_I2C_TARGET_CLOCK_STRETCH_EN
        if (tx_wait_q && tx_valid) begin
          shift_q    <= tx_data;
          sda_t_q    <= tx_data[7];
          tx_ready_q <= 1'b1;
          scl_t_q    <= I2C_RELEASED;
          tx_wait_q  <= 1'b0;
        end
        if (rx_wait_q && !rx_valid_q) begin
          rx_valid_q   <= 1'b1;
          rx_data_q    <= shift_q;
          rx_first_q   <= first_pend_q;
          first_pend_q <= 1'b0;
          sda_t_q      <= 1'b0;
          scl_t_q      <= I2C_RELEASED;
          rx_wait_q    <= 1'b0;
        end
`endif
      end
    end
  end
  assign scl_o       = 1'b0;
  assign sda_o       = 1'b0;
  assign sda_t       = sda_t_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_first    = rx_first_q;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign start_pulse = start_q;
  assign stop_pulse  = stop_q;
  assign err_pulse   = err_q;
endmodule
